// File: rtl/n64_sdram_arbiter_if.sv
// if_system: shared clock/reset bundle for system-level blocks.
//   clk   - system clock
//   reset - synchronous active-high reset
// Modport sys is the consumer view (both signals are inputs).
interface if_system;
  logic clk;
  logic reset;

  modport sys (
    input clk,
    input reset
  );
endinterface

// File: rtl/n64_sdram_arbiter.sv
// n64_sdram_arbiter: shares one SDRAM controller port between the N64 PI
// bus and the DMA engine, and schedules periodic auto-refresh.
// Priority: refresh, then N64, then DMA. DMA is forced after a bounded run
// of N64 grants while it waits.
//
// Ports:
//   sys                 clock / synchronous active-high reset
//   n64_request/write/address/wdata  single-cycle N64 access pulse + fields
//   n64_ack, n64_rdata  N64 completion strobe, read data (0 when no ack)
//   dma_request/write/address/wdata  level DMA request (held to dma_ack)
//   dma_ack, dma_rdata  DMA completion strobe, read data (0 when no ack)
//   mem_request         command valid, held until mem_ack
//   mem_write/address/wdata          latched command fields
//   mem_ack, mem_rdata  controller completion strobe and read data
//   mem_refresh         refresh command, held until mem_refresh_ack
//   mem_refresh_ack     refresh-done strobe
//   refresh_overrun     sticky: refresh interval expired with refresh pending
//   n64_overrun         sticky: N64 request dropped (previous one still busy)
module n64_sdram_arbiter #(
  parameter int ADDR_W           = 26,
  parameter int REFRESH_INTERVAL = 780,
  parameter int DMA_STARVE_LIMIT = 4
) (
  if_system.sys             sys,
  input  logic              n64_request,
  input  logic              n64_write,
  input  logic [ADDR_W-1:0] n64_address,
  input  logic [15:0]       n64_wdata,
  output logic              n64_ack,
  output logic [15:0]       n64_rdata,
  input  logic              dma_request,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [15:0]       dma_wdata,
  output logic              dma_ack,
  output logic [15:0]       dma_rdata,
  output logic              mem_request,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              mem_refresh,
  input  logic              mem_refresh_ack,
  output logic              refresh_overrun,
  output logic              n64_overrun
);

  localparam int CNT_W    = $clog2(REFRESH_INTERVAL);
  localparam int STREAK_W = $clog2(DMA_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DMA_STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFRESH,
    S_N64,
    S_DMA
  } state_t;

  state_t state, next_state;

  logic              n64_pending;
  logic              n64_pend_write;
  logic [ADDR_W-1:0] n64_pend_address;
  logic [15:0]       n64_pend_wdata;

  logic                refresh_pending;
  logic [CNT_W-1:0]    refresh_cnt;
  logic [STREAK_W-1:0] streak;

  logic grant_n64;
  logic grant_dma;

  logic refresh_tick;
  logic n64_want;
  logic n64_busy;
  logic n64_accept;

  assign refresh_tick = (refresh_cnt == '0);
  assign n64_want     = n64_pending | n64_request;
  // An access whose mem_ack lands this cycle is finished, so a new pulse in
  // that same cycle is accepted rather than counted as an overrun.
  assign n64_busy     = n64_pending | ((state == S_N64) & ~mem_ack);
  assign n64_accept   = n64_request & ~n64_busy;

  // State register
  always_ff @(posedge sys.clk) begin
    if (sys.reset) state <= S_IDLE;
    else           state <= next_state;
  end

  // Arbitration / next state. The expiring timer counts as a refresh request
  // so an idle arbiter issues mem_refresh the cycle after the counter hits 0.
  always_comb begin
    next_state = state;
    grant_n64  = 1'b0;
    grant_dma  = 1'b0;
    case (state)
      S_IDLE: begin
        if (refresh_pending | refresh_tick) begin
          next_state = S_REFRESH;
        end else if (n64_want && dma_request && (streak == STREAK_MAX)) begin
          grant_dma  = 1'b1;
          next_state = S_DMA;
        end else if (n64_want) begin
          grant_n64  = 1'b1;
          next_state = S_N64;
        end else if (dma_request) begin
          grant_dma  = 1'b1;
          next_state = S_DMA;
        end
      end
      S_REFRESH: if (mem_refresh_ack) next_state = S_IDLE;
      S_N64:     if (mem_ack)         next_state = S_IDLE;
      S_DMA:     if (mem_ack)         next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // N64 capture: the pending flag is control, the captured fields are data
  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      n64_pending <= 1'b0;
      n64_overrun <= 1'b0;
    end else begin
      if (grant_n64)       n64_pending <= 1'b0;
      else if (n64_accept) n64_pending <= 1'b1;
      if (n64_request && n64_busy) n64_overrun <= 1'b1;
    end
  end

  always_ff @(posedge sys.clk) begin
    if (n64_accept) begin
      n64_pend_write   <= n64_write;
      n64_pend_address <= n64_address;
      n64_pend_wdata   <= n64_wdata;
    end
  end

  // Refresh timer
  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      refresh_cnt     <= CNT_RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      if (refresh_tick) refresh_cnt <= CNT_RELOAD;
      else              refresh_cnt <= refresh_cnt - CNT_W'(1);

      if (refresh_tick) begin
        refresh_pending <= 1'b1;
        if (refresh_pending) refresh_overrun <= 1'b1;
      end else if ((state == S_REFRESH) && mem_refresh_ack) begin
        refresh_pending <= 1'b0;
      end
    end
  end

  // Starvation streak
  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      streak <= '0;
    end else if (!dma_request || grant_dma) begin
      streak <= '0;
    end else if (grant_n64 && (streak != STREAK_MAX)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  // Command field capture on grant. A fresh N64 pulse granted in the same
  // cycle bypasses the pending latch.
  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else if (grant_n64) begin
      mem_write   <= n64_pending ? n64_pend_write   : n64_write;
      mem_address <= n64_pending ? n64_pend_address : n64_address;
      mem_wdata   <= n64_pending ? n64_pend_wdata   : n64_wdata;
    end else if (grant_dma) begin
      mem_write   <= dma_write;
      mem_address <= dma_address;
      mem_wdata   <= dma_wdata;
    end
  end

  assign mem_request = (state == S_N64) | (state == S_DMA);
  assign mem_refresh = (state == S_REFRESH);
  assign n64_ack     = (state == S_N64) & mem_ack;
  assign dma_ack     = (state == S_DMA) & mem_ack;
  assign n64_rdata   = n64_ack ? mem_rdata : 16'h0000;
  assign dma_rdata   = dma_ack ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_n64_sdram_arbiter.sv
// tb_n64_sdram_arbiter: directed bench for n64_sdram_arbiter. One instance
// uses the default refresh interval for traffic tests, a second instance
// uses a 16-cycle interval for refresh tests. Both share clock and reset.
module tb_n64_sdram_arbiter;

  if_system sys_if ();

  initial sys_if.clk = 1'b0;
  always #5 sys_if.clk = ~sys_if.clk;

  // Traffic instance signals
  logic        n64_request, n64_write, n64_ack;
  logic [25:0] n64_address;
  logic [15:0] n64_wdata, n64_rdata;
  logic        dma_request, dma_write, dma_ack;
  logic [25:0] dma_address;
  logic [15:0] dma_wdata, dma_rdata;
  logic        mem_request, mem_write, mem_ack;
  logic [25:0] mem_address;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_refresh, mem_refresh_ack, refresh_overrun, n64_overrun;

  // Refresh instance signals
  logic        r_n64_request, r_n64_write, r_n64_ack;
  logic [25:0] r_n64_address;
  logic [15:0] r_n64_wdata, r_n64_rdata;
  logic        r_dma_request, r_dma_write, r_dma_ack;
  logic [25:0] r_dma_address;
  logic [15:0] r_dma_wdata, r_dma_rdata;
  logic        r_mem_request, r_mem_write, r_mem_ack;
  logic [25:0] r_mem_address;
  logic [15:0] r_mem_wdata, r_mem_rdata;
  logic        r_mem_refresh, r_mem_refresh_ack, r_refresh_overrun, r_n64_overrun;

  n64_sdram_arbiter #(.ADDR_W(26), .REFRESH_INTERVAL(780), .DMA_STARVE_LIMIT(4)) dut (
    .sys(sys_if),
    .n64_request(n64_request), .n64_write(n64_write), .n64_address(n64_address),
    .n64_wdata(n64_wdata), .n64_ack(n64_ack), .n64_rdata(n64_rdata),
    .dma_request(dma_request), .dma_write(dma_write), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_refresh(mem_refresh), .mem_refresh_ack(mem_refresh_ack),
    .refresh_overrun(refresh_overrun), .n64_overrun(n64_overrun)
  );

  n64_sdram_arbiter #(.ADDR_W(26), .REFRESH_INTERVAL(16), .DMA_STARVE_LIMIT(4)) dut_r (
    .sys(sys_if),
    .n64_request(r_n64_request), .n64_write(r_n64_write), .n64_address(r_n64_address),
    .n64_wdata(r_n64_wdata), .n64_ack(r_n64_ack), .n64_rdata(r_n64_rdata),
    .dma_request(r_dma_request), .dma_write(r_dma_write), .dma_address(r_dma_address),
    .dma_wdata(r_dma_wdata), .dma_ack(r_dma_ack), .dma_rdata(r_dma_rdata),
    .mem_request(r_mem_request), .mem_write(r_mem_write), .mem_address(r_mem_address),
    .mem_wdata(r_mem_wdata), .mem_ack(r_mem_ack), .mem_rdata(r_mem_rdata),
    .mem_refresh(r_mem_refresh), .mem_refresh_ack(r_mem_refresh_ack),
    .refresh_overrun(r_refresh_overrun), .n64_overrun(r_n64_overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_if.clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] exp_seq [10];
    int waitc;
    int acks;
    int rise [3];
    int nr;
    int k;
    logic prev;

    n64_request = 0; n64_write = 0; n64_address = '0; n64_wdata = '0;
    dma_request = 0; dma_write = 0; dma_address = '0; dma_wdata = '0;
    mem_ack = 0; mem_rdata = 16'hA5A5; mem_refresh_ack = 0;
    r_n64_request = 0; r_n64_write = 0; r_n64_address = '0; r_n64_wdata = '0;
    r_dma_request = 0; r_dma_write = 0; r_dma_address = '0; r_dma_wdata = '0;
    r_mem_ack = 0; r_mem_rdata = '0; r_mem_refresh_ack = 0;
    for (int g = 0; g < 10; g++) exp_seq[g] = (g == 4 || g == 9) ? 26'h300 : 26'h200;

    sys_if.reset = 1;
    step(); step();
    sys_if.reset = 0;

    // Reset state
    check_val("rst_mem_request", 32'(mem_request), 0);
    check_val("rst_mem_refresh", 32'(mem_refresh), 0);
    check_val("rst_acks", 32'({n64_ack, dma_ack}), 0);
    check_val("rst_overruns", 32'({refresh_overrun, n64_overrun}), 0);
    check_val("rst_mem_address", 32'(mem_address), 0);
    check_val("rst_rdata_gated", 32'({n64_rdata, dma_rdata}), 0);

    // Single N64 read, controller acks 3 cycles later with 0xBEEF
    mem_rdata = 16'h0000;
    n64_request = 1; n64_write = 0; n64_address = 26'h100;
    step();
    n64_request = 0;
    check_val("t1_mem_request", 32'(mem_request), 1);
    check_val("t1_mem_address", 32'(mem_address), 32'h100);
    check_val("t1_mem_write", 32'(mem_write), 0);
    step(); step();
    check_val("t1_no_early_ack", 32'({n64_ack, mem_request}), 32'b01);
    step();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    #1;
    check_val("t1_n64_ack", 32'(n64_ack), 1);
    check_val("t1_n64_rdata", 32'(n64_rdata), 32'hBEEF);
    check_val("t1_dma_ack", 32'(dma_ack), 0);
    step();
    mem_ack = 0; mem_rdata = 16'h0000;
    check_val("t1_req_drop", 32'(mem_request), 0);

    // Starvation guard: N64 x4, DMA, N64 x4, DMA
    n64_request = 1; n64_write = 0; n64_address = 26'h200;
    dma_request = 1; dma_write = 1; dma_address = 26'h300; dma_wdata = 16'h5555;
    step();
    n64_request = 0;
    check_val("t2_grant_latency", 32'(mem_request), 1);
    for (int g = 0; g < 10; g++) begin
      waitc = 0;
      while (!mem_request && waitc < 20) begin
        step();
        waitc++;
      end
      check_val($sformatf("t2_grant%0d_req", g), 32'(mem_request), 1);
      check_val($sformatf("t2_grant%0d_addr", g), 32'(mem_address), 32'(exp_seq[g]));
      mem_ack = 1; mem_rdata = 16'(g);
      if (exp_seq[g] == 26'h200) n64_request = 1;
      #1;
      check_val($sformatf("t2_grant%0d_ack", g), 32'({n64_ack, dma_ack}),
                (exp_seq[g] == 26'h200) ? 32'b10 : 32'b01);
      step();
      mem_ack = 0; n64_request = 0;
    end
    dma_request = 0;
    waitc = 0;
    while (!mem_request && waitc < 20) begin
      step();
      waitc++;
    end
    check_val("t2_tail_addr", 32'({mem_request, mem_address}), 32'({1'b1, 26'h200}));
    mem_ack = 1;
    step();
    mem_ack = 0;
    check_val("t2_ack_edge_no_overrun", 32'(n64_overrun), 0);

    // Second N64 request while the first is in flight
    n64_request = 1; n64_write = 1; n64_address = 26'h600; n64_wdata = 16'hCAFE;
    step();
    check_val("t3_mem_request", 32'(mem_request), 1);
    check_val("t3_mem_wdata", 32'(mem_wdata), 32'hCAFE);
    check_val("t3_mem_write", 32'(mem_write), 1);
    n64_address = 26'h700;
    step();
    n64_request = 0;
    check_val("t3_n64_overrun", 32'(n64_overrun), 1);
    acks = 0;
    mem_ack = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      acks += int'(n64_ack);
      step();
      mem_ack = 0;
    end
    check_val("t3_single_ack", 32'(acks), 1);
    check_val("t3_dropped_not_served", 32'(mem_request), 0);

    // Reset pulsed mid-access
    dma_request = 1; dma_write = 0; dma_address = 26'h400;
    step();
    check_val("t4_mem_request", 32'(mem_request), 1);
    sys_if.reset = 1; dma_request = 0;
    step();
    sys_if.reset = 0;
    check_val("t4_rst_outputs", 32'({mem_request, mem_refresh, n64_ack, dma_ack,
                                      refresh_overrun, n64_overrun}), 0);
    check_val("t4_rst_mem_address", 32'(mem_address), 0);
    dma_request = 1; dma_write = 1; dma_address = 26'h500; dma_wdata = 16'h1234;
    step();
    check_val("t4_regrant", 32'({mem_request, mem_write}), 32'b11);
    check_val("t4_regrant_addr", 32'(mem_address), 32'h500);
    check_val("t4_regrant_wdata", 32'(mem_wdata), 32'h1234);
    mem_ack = 1; mem_rdata = 16'h0F0F;
    #1;
    check_val("t4_dma_ack", 32'({dma_ack, n64_ack}), 32'b10);
    check_val("t4_dma_rdata", 32'(dma_rdata), 32'h0F0F);
    step();
    mem_ack = 0; dma_request = 0;
    step();
    check_val("t4_idle_after", 32'(mem_request), 0);

    // Refresh cadence with 16-cycle interval, then overrun
    sys_if.reset = 1;
    step(); step();
    sys_if.reset = 0;
    nr = 0; k = 0; prev = 0;
    while (nr < 3 && k < 100) begin
      if (r_mem_refresh && !prev) begin
        rise[nr] = k;
        nr++;
      end
      prev = r_mem_refresh;
      if (r_mem_refresh && nr < 3) r_mem_refresh_ack = 1;
      step();
      k++;
      r_mem_refresh_ack = 0;
    end
    check_val("r1_rise_count", 32'(nr), 3);
    check_val("r1_first_rise", 32'(rise[0]), 16);
    check_val("r1_period_a", 32'(rise[1] - rise[0]), 16);
    check_val("r1_period_b", 32'(rise[2] - rise[1]), 16);
    check_val("r1_no_overrun_yet", 32'(r_refresh_overrun), 0);
    repeat (20) step();
    check_val("r1_refresh_held", 32'(r_mem_refresh), 1);
    check_val("r1_refresh_overrun", 32'(r_refresh_overrun), 1);
    r_mem_refresh_ack = 1;
    step();
    r_mem_refresh_ack = 0;
    check_val("r1_refresh_drop", 32'(r_mem_refresh), 0);

    // Refresh due during a DMA access
    sys_if.reset = 1;
    step(); step();
    sys_if.reset = 0;
    repeat (10) step();
    r_dma_request = 1; r_dma_write = 0; r_dma_address = 26'h800;
    step();
    check_val("r2_dma_granted", 32'(r_mem_request), 1);
    r_n64_request = 1; r_n64_write = 0; r_n64_address = 26'h900;
    step();
    r_n64_request = 0;
    repeat (4) step();
    check_val("r2_no_preempt", 32'({r_mem_refresh, r_mem_request}), 32'b01);
    repeat (4) step();
    r_mem_ack = 1;
    #1;
    check_val("r2_dma_ack", 32'(r_dma_ack), 1);
    step();
    r_mem_ack = 0; r_dma_request = 0;
    check_val("r2_idle", 32'({r_mem_refresh, r_mem_request}), 0);
    step();
    check_val("r2_refresh_first", 32'({r_mem_refresh, r_mem_request}), 32'b10);
    r_mem_refresh_ack = 1;
    step();
    r_mem_refresh_ack = 0;
    check_val("r2_refresh_done", 32'({r_mem_refresh, r_mem_request}), 0);
    step();
    check_val("r2_n64_after", 32'({r_mem_request, r_mem_address}), 32'({1'b1, 26'h900}));
    r_mem_ack = 1;
    #1;
    check_val("r2_n64_ack", 32'(r_n64_ack), 1);
    step();
    r_mem_ack = 0;
    check_val("r2_no_overruns", 32'({r_refresh_overrun, r_n64_overrun}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
